// File: rtl/scb_pkg.sv
// Shared types and constants for the forwarding scoreboard: the entry record, select encoding and default ready stages.
package scb_pkg;

   // Entries are stored at fixed widths; REG_ADDR_W and stage indices must fit in these.
   localparam int SCB_ADDR_W_MAX = 8;
   localparam int SCB_STAGE_W    = 4;

   localparam int SEL_RF  = 0;
   localparam int SEL_MEM = 1;
   localparam int SEL_WB  = 2;

   // A result becomes forwardable at the stage whose select code names it.
   localparam int READY_ALU_DEF  = SEL_MEM;
   localparam int READY_LOAD_DEF = SEL_WB;

   typedef struct packed {
      logic                      valid;
      logic [SCB_ADDR_W_MAX-1:0] dest;
      logic [SCB_STAGE_W-1:0]    ready_stage;
   } entry_t;

endpackage

// File: rtl/scb_match.sv
// Youngest-producer search for one source operand across the tracked stages, with readiness for the EX and ID rules.
module scb_match
   import scb_pkg::*;
#(
   parameter int PIPE_DEPTH = 3,
   parameter int REG_ADDR_W = 5,
   parameter int SEL_W      = 2
) (
   input  entry_t [PIPE_DEPTH-1:0] entries,
   input  logic [REG_ADDR_W-1:0]   src,
   input  logic                    used,
   output logic                    hit,
   output logic [SEL_W-1:0]        stage,
   output logic                    ex_ready,
   output logic                    id_ready
);

   logic [SCB_STAGE_W-1:0] rdy;

   // Scan oldest to youngest so the lowest matching index is what remains.
   always_comb begin
      hit   = 1'b0;
      stage = '0;
      rdy   = '0;
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
         if (used && (src != '0) && entries[k].valid &&
             (entries[k].dest == SCB_ADDR_W_MAX'(src))) begin
            hit   = 1'b1;
            stage = SEL_W'(k);
            rdy   = entries[k].ready_stage;
         end
      end
   end

   // A producer in the last stage is written to the RF on this edge, so EX never waits on it.
   assign ex_ready = (int'(stage) == PIPE_DEPTH - 1) || (int'(rdy) <= int'(stage) + 1);
   assign id_ready = (stage != '0) && (int'(rdy) <= int'(stage));

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard beside ID/EX: issue stall, ID and registered EX forward selects.
// Optional SCB_PERF_CNT_EN adds saturating stall_cnt and fwd_cnt outputs.
module fwd_scoreboard
   import scb_pkg::*;
#(
   parameter int  PIPE_DEPTH = 3,
   parameter int  REG_ADDR_W = 5,
   parameter int  ALU_READY  = READY_ALU_DEF,
   parameter int  LOAD_READY = READY_LOAD_DEF,
   parameter int  CNT_W      = 32,
   localparam int SEL_W      = $clog2(PIPE_DEPTH)
) (
   input  logic                  clk,
   input  logic                  Reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_rs_used,
   input  logic                  id_rt_used,
   input  logic                  id_early_use,
   input  logic                  id_regwrite,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_is_load,
   input  logic                  ext_stall,
   input  logic                  ex_flush,
   output logic                  issue_stall,
   output logic [SEL_W-1:0]      id_rs_sel,
   output logic [SEL_W-1:0]      id_rt_sel,
   output logic [SEL_W-1:0]      ex_rs_sel,
   output logic [SEL_W-1:0]      ex_rt_sel
`ifdef SCB_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      fwd_cnt
`endif
);

   entry_t [PIPE_DEPTH-1:0]        entry_reg;
   entry_t                         new_entry;
   logic [1:0][REG_ADDR_W-1:0]     op_src;
   logic [1:0]                     op_used;
   logic [1:0]                     op_hazard;
   logic [1:0][SEL_W-1:0]          op_ex_sel;
   logic [1:0][SEL_W-1:0]          op_id_sel;
   logic                           issue;

   // Operand 0 is rs, operand 1 is rt.
   assign op_src  = {id_rt, id_rs};
   assign op_used = {id_rt_used, id_rs_used};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_op
         logic             hit;
         logic [SEL_W-1:0] stage;
         logic             ex_ready;
         logic             id_ready;
         logic             hazard;
         logic [SEL_W-1:0] ex_sel;
         logic [SEL_W-1:0] id_sel;

         scb_match #(
            .PIPE_DEPTH (PIPE_DEPTH),
            .REG_ADDR_W (REG_ADDR_W),
            .SEL_W      (SEL_W)
         ) u_match (
            .entries  (entry_reg),
            .src      (op_src[gi]),
            .used     (op_used[gi]),
            .hit      (hit),
            .stage    (stage),
            .ex_ready (ex_ready),
            .id_ready (id_ready)
         );

         // In EX the producer will have advanced one stage beyond where it sits now.
         always_comb begin
            hazard = 1'b0;
            ex_sel = SEL_W'(SEL_RF);
            id_sel = SEL_W'(SEL_RF);
            if (hit) begin
               if (!ex_ready) begin
                  hazard = 1'b1;
               end else if (int'(stage) != PIPE_DEPTH - 1) begin
                  ex_sel = stage + SEL_W'(1);
               end
               if (id_early_use) begin
                  if (id_ready) begin
                     id_sel = stage;
                  end else begin
                     hazard = 1'b1;
                  end
               end
            end
         end

         assign op_hazard[gi] = hazard;
         assign op_ex_sel[gi] = ex_sel;
         assign op_id_sel[gi] = id_sel;
      end
   endgenerate

   assign issue_stall = id_valid & (|op_hazard);
   assign issue       = id_valid & ~ex_flush & ~issue_stall;
   assign id_rs_sel   = op_id_sel[0];
   assign id_rt_sel   = op_id_sel[1];

   always_comb begin
      new_entry.valid       = issue & id_regwrite;
      new_entry.dest        = SCB_ADDR_W_MAX'(id_dest);
      new_entry.ready_stage = SCB_STAGE_W'(id_is_load ? LOAD_READY : ALU_READY);
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         entry_reg <= '0;
         ex_rs_sel <= SEL_W'(SEL_RF);
         ex_rt_sel <= SEL_W'(SEL_RF);
      end else if (!ext_stall) begin
         for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
            entry_reg[k] <= entry_reg[k-1];
         end
         entry_reg[0] <= new_entry;
         ex_rs_sel    <= issue ? op_ex_sel[0] : SEL_W'(SEL_RF);
         ex_rt_sel    <= issue ? op_ex_sel[1] : SEL_W'(SEL_RF);
      end
   end

`ifdef SCB_PERF_CNT_EN
   localparam int              SUM_W   = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [SUM_W-1:0] fwd_sum;

   // One extra bit catches the +2 case overflowing so the count clamps instead of wrapping.
   assign fwd_sum = {1'b0, fwd_cnt}
                  + SUM_W'(issue & (|op_ex_sel[0]))
                  + SUM_W'(issue & (|op_ex_sel[1]));

   always_ff @(posedge clk) begin
      if (Reset) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else if (!ext_stall) begin
         if (issue_stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         fwd_cnt <= fwd_sum[CNT_W] ? CNT_MAX : fwd_sum[CNT_W-1:0];
      end
   end
`endif

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
Parametrised successor to the fixed MEM/WB forwarding and hazard logic of the 5-stage core. Tracks every in-flight register write in a PIPE_DEPTH-entry shift register (index 0 = EX, 1 = MEM, 2 = WB by default) and tags each write with the stage at which its result becomes forwardable. Produces the ID-stage issue stall, combinational ID-stage forward selects for branch/JR operands, and registered EX-stage forward selects. Sits beside the ID/EX register and drives the forwarding muxes directly.

Parameters:
PIPE_DEPTH, 3, number of tracked stages after ID (EX..WB)
REG_ADDR_W, 5, register specifier width
ALU_READY, 1, stage index at which a non-load result is forwardable
LOAD_READY, 2, stage index at which load data is forwardable (>= ALU_READY, < PIPE_DEPTH)
CNT_W, 32, perf counter width
SEL_W, clog2(PIPE_DEPTH), derived width of the select fields; must not be overridden

Ports:
clk  in  1  core clock
Reset  in  1  synchronous, active-high reset
id_valid  in  1  valid instruction in ID
id_rs / id_rt  in  REG_ADDR_W  source specifiers
id_rs_used / id_rt_used  in  1  operand actually read
id_early_use  in  1  operands consumed in ID (branch compare, JR)
id_regwrite  in  1  instruction writes a register
id_dest  in  REG_ADDR_W  final destination (after RegDst/link resolution)
id_is_load  in  1  result comes from memory
ext_stall  in  1  freeze entire tracker (e.g. memory wait)
ex_flush  in  1  squash the instruction entering EX
issue_stall  out  1  hold PC and IF/ID; insert bubble into EX
id_rs_sel / id_rt_sel  out  SEL_W  ID forward select (0 = RF, k = stage k)
ex_rs_sel / ex_rt_sel  out  SEL_W  registered EX forward select (same encoding)

Behaviour:
- Entry per stage: valid, dest, ready_stage (ALU_READY or LOAD_READY). An entry matches an operand if valid, dest == src, dest != 0, and the operand is used.
- Youngest match wins: lowest stage index.
- EX path (operand enters EX next cycle, producer then at s+1):
  - If s+1 >= PIPE_DEPTH, no hazard (RF written this edge); select 0.
  - Else if ready_stage <= s+1, select s+1.
  - Else hazard.
- ID path, when id_early_use: producer at s.
  - If ready_stage <= s, id_*_sel = s.
  - Else hazard. Stage 0 is never ready.
  - id_*_sel is 0 when there is no match or id_early_use is low.
- issue_stall = id_valid & (any hazard on either operand); purely combinational, 0 cycles latency.
- Edge priority:
  1. Reset: all entries invalid; ex_*_sel = 0.
  2. ext_stall: entries and ex_*_sel hold; issue_stall still computed.
  3. ex_flush or issue_stall or !id_valid: shift; stage 0 gets a bubble; ex_*_sel = 0.
  4. Otherwise: shift; stage 0 gets {id_regwrite, id_dest, ready}; ex_*_sel take the computed EX selects.
- Shift: entry k moves to k+1; the entry at PIPE_DEPTH-1 is discarded.
- Default depth 3 with load in EX and a dependent ALU op in ID: exactly one stall cycle, then select 2 (WB).
- Reset mid-stream: no stale forwarding; the first post-reset instruction sees all selects 0.

Optional Feature:
SCB_PERF_CNT_EN:
- When defined, adds outputs stall_cnt and fwd_cnt (CNT_W each), both cleared by Reset and saturating at all-ones.
  - stall_cnt increments on every non-ext_stall cycle with issue_stall = 1.
  - fwd_cnt increments per nonzero ex_*_sel loaded on an issue (+2 if both).
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package scb_pkg:
  - entry typedef (valid, dest, ready_stage)
  - select encoding constants SEL_RF = 0, SEL_MEM = 1, SEL_WB = 2
  - default ready-stage constants
- Sub-module scb_match: per-operand youngest-match priority encoder over the entry vector. Returns hit, stage index and ready flag for the EX and ID rules. Instantiated twice (rs, rt).

Test Plan:
- add $3 then sub $4,$3,$5 back-to-back → no stall; ex_rs_sel = 1.
- lw $3 then add $4,$3,$3 → issue_stall = 1 for exactly 1 cycle; then ex_rs_sel = ex_rt_sel = 2.
- add $2 then beq $2,$0 (id_early_use) → stall 1 cycle, then id_rs_sel = 1. With lw $2 instead → 2 stall cycles, then id_rs_sel = 2.
- Writes to $0 → never stall or forward. Two producers of $7 at stages 0 and 1 → the stage-0 (youngest) producer is selected.
- ext_stall held 3 cycles with lw in EX → entries and ex_*_sel frozen. ex_flush on an issuing add → stage 0 bubble, no later forward from it.
- Reset asserted mid-sequence → next cycle all selects 0 and issue_stall 0. With SCB_PERF_CNT_EN, counters read 0, then count 1 stall after a load-use.
